// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the delay_sched timer scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int COUNTER91_LAT = 92;  // counter91 ld-to-dn cycles
  localparam int WD_W          = 8;

endpackage

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    idx
);

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    logic [PW:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (req[cand[PW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Round-robin owner of one shared counter91 timer: grant, load, wait for dn, pulse done.
// Define DELAY_SCHED_WATCHDOG_EN to abort a WAIT lasting WD_LIMIT cycles and raise sticky err.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WD_LIMIT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             tmr_ld,
  input  logic             tmr_dn,
  output logic             busy,
  output logic             err
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_bad_param
    $error("delay_sched: N_REQ must be 2..16 and WD_LIMIT 1..255");
  end

  state_t           state;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    ptr;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] idx_oh;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .valid(pick_vld),
    .idx  (pick_idx)
  );

  assign pick_oh = N_REQ'(1) << pick_idx;
  assign idx_oh  = N_REQ'(1) << idx;

  function automatic logic [PW-1:0] after(input logic [PW-1:0] i);
    return (i == PW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef DELAY_SCHED_WATCHDOG_EN
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wd <= '0;
    else if (state == LOAD) wd <= '0;
    else if (state == WAIT) wd <= wd + 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      ptr    <= '0;
      gnt    <= '0;
      done   <= '0;
      tmr_ld <= 1'b0;
      busy   <= 1'b0;
`ifdef DELAY_SCHED_WATCHDOG_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (pick_vld) begin
            idx    <= pick_idx;
            gnt    <= pick_oh;
            tmr_ld <= 1'b1;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          tmr_ld <= 1'b0;
          state  <= WAIT;
        end
        // Stale dn from the previous job is only masked because it is never looked at outside WAIT.
        WAIT: begin
          if (tmr_dn) begin
            done  <= idx_oh;
            state <= DONE;
          end
`ifdef DELAY_SCHED_WATCHDOG_EN
          else if (wd == WD_W'(WD_LIMIT - 1)) begin
            err   <= 1'b1;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= after(idx);
            state <= IDLE;
          end
`endif
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= after(idx);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
